// File: rtl/timer_dev_if.sv
// Bridge-bus port bundle for timer_dev: word address, write strobe and data in,
// combinational read data and the interrupt request out.
interface timer_dev_if;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    modport master (output Addr, We, DIn, input DOut, IRQ);
    modport slave  (input Addr, We, DIn, output DOut, IRQ);
endinterface

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer, one-shot or auto-reload, with a masked IRQ.
// Defining TIMER_PRESCALE_EN adds a PRESCALE register at Addr 3 that slows the count.
module timer_dev #(
    parameter int PRESCALE_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    timer_dev_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;

    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_e                state_q, state_d;
    logic [3:0]            ctrl_q, ctrl_d;
    logic [31:0]           preset_q, preset_d;
    logic [31:0]           count_q, count_d;
    logic                  irq_flag_q, irq_flag_d;
    logic                  irq_q, irq_d;
    logic                  flag_set, flag_clr;
    logic                  tick;
    logic [PRESCALE_W-1:0] prescale_q;

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_d, psc_cnt_q, psc_cnt_d;
    assign tick = (psc_cnt_q == '0);
`else
    assign tick       = 1'b1;
    assign prescale_q = '0;
`endif

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_set = 1'b0;
        flag_clr = 1'b0;
`ifdef TIMER_PRESCALE_EN
        prescale_d = prescale_q;
        psc_cnt_d  = psc_cnt_q;
`endif
        unique case (state_q)
            IDLE: if (ctrl_q[0]) state_d = LOAD;
            LOAD: begin
                if (!ctrl_q[0]) begin
                    state_d = IDLE;
                end else begin
                    count_d = preset_q;
`ifdef TIMER_PRESCALE_EN
                    psc_cnt_d = prescale_q;
`endif
                    state_d = CNT;
                end
            end
            CNT: begin
                if (!ctrl_q[0]) begin
                    state_d = IDLE;
                end else if (tick) begin
`ifdef TIMER_PRESCALE_EN
                    psc_cnt_d = prescale_q;
`endif
                    // Expire on 1 (or 0 from PRESET=0) so COUNT never wraps.
                    if (count_q <= 32'd1) begin
                        count_d  = '0;
                        flag_set = 1'b1;
                        state_d  = INT;
                    end else begin
                        count_d = count_q - 32'd1;
                    end
                end
`ifdef TIMER_PRESCALE_EN
                else begin
                    psc_cnt_d = psc_cnt_q - PRESCALE_W'(1);
                end
`endif
            end
            INT: begin
                if (ctrl_q[2:1] == MODE_RELOAD) begin
                    flag_clr = 1'b1;
                    state_d  = LOAD;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Software writes are applied last so a CTRL write beats the one-shot Enable clear.
        if (bus.We) begin
            unique case (bus.Addr)
                2'd0: begin
                    ctrl_d   = bus.DIn[3:0];
                    flag_clr = 1'b1;
                end
                2'd1: preset_d = bus.DIn;
`ifdef TIMER_PRESCALE_EN
                2'd3: prescale_d = bus.DIn[PRESCALE_W-1:0];
`endif
                default: ;
            endcase
        end

        // A new expiry is never lost to a simultaneous clear.
        irq_flag_d = flag_set | (irq_flag_q & ~flag_clr);
        irq_d      = ctrl_d[3] & irq_flag_d;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            irq_q      <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            prescale_q <= '0;
            psc_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            irq_q      <= irq_d;
`ifdef TIMER_PRESCALE_EN
            prescale_q <= prescale_d;
            psc_cnt_q  <= psc_cnt_d;
`endif
        end
    end

    always_comb begin
        unique case (bus.Addr)
            2'd0:    bus.DOut = {28'd0, ctrl_q};
            2'd1:    bus.DOut = preset_q;
            2'd2:    bus.DOut = count_q;
            default: bus.DOut = 32'(prescale_q);
        endcase
    end

    // IRQ comes straight from a flop, so it cannot glitch and drops with async reset.
    assign bus.IRQ = irq_q;
endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: a register-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed edge counts and read values.
module tb_timer_dev;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   edge_cnt = 0;
    int   e0, e1;

    timer_dev_if bus ();

    timer_dev dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: timer phases 0=idle, 1=arming, 2=counting, 3=expired.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset, m_count;
    logic        m_flag;
    int          m_phase;
    int unsigned m_psc, m_prescale;

    function automatic void model_step();
        logic [3:0] mc;
        bit         mset, mclr;
        mc   = m_ctrl;
        mset = 0;
        mclr = 0;
        if (m_phase == 0) begin
            if (m_ctrl[0]) m_phase = 1;
        end else if (!m_ctrl[0] && m_phase != 3) begin
            m_phase = 0;
        end else if (m_phase == 1) begin
            m_count = m_preset;
            m_psc   = m_prescale;
            m_phase = 2;
        end else if (m_phase == 2) begin
            if (m_psc > 0) begin
                m_psc = m_psc - 1;
            end else begin
                m_psc = m_prescale;
                if (m_count <= 1) begin
                    m_count = 0;
                    mset    = 1;
                    m_phase = 3;
                end else begin
                    m_count = m_count - 1;
                end
            end
        end else begin
            if (m_ctrl[2:1] == 2'b01) begin
                mclr    = 1;
                m_phase = 1;
            end else begin
                mc[0]   = 1'b0;
                m_phase = 0;
            end
        end
        if (bus.We) begin
            case (bus.Addr)
                2'd0: begin
                    mc   = bus.DIn[3:0];
                    mclr = 1;
                end
                2'd1: m_preset = bus.DIn;
`ifdef TIMER_PRESCALE_EN
                2'd3: m_prescale = bus.DIn % 256;
`endif
                default: ;
            endcase
        end
        m_ctrl = mc;
        m_flag = mset | (m_flag & !mclr);
    endfunction

    function automatic void model_reset();
        m_ctrl     = 0;
        m_preset   = 0;
        m_count    = 0;
        m_flag     = 0;
        m_phase    = 0;
        m_psc      = 0;
        m_prescale = 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return m_prescale;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(negedge clk) begin
        check("cyc_irq", {31'd0, bus.IRQ}, {31'd0, m_ctrl[3] & m_flag});
        check("cyc_dout", bus.DOut, m_read(bus.Addr));
    end

    task automatic wr_now(input logic [1:0] a, input logic [31:0] d);
        bus.Addr = a;
        bus.DIn  = d;
        bus.We   = 1'b1;
        @(posedge clk);
        #2 bus.We = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #2 wr_now(a, d);
    endtask

    task automatic rd_expect(input logic [1:0] a, input logic [31:0] exp, input string name);
        bus.Addr = a;
        #1 check(name, bus.DOut, exp);
    endtask

    task automatic wait_irq(input int start, input int edges, input string name);
        for (int i = 0; i < 300 && !bus.IRQ; i++) begin
            @(posedge clk);
            #1;
        end
        check(name, edge_cnt - start, edges);
    endtask

    task automatic poll_count(input logic [31:0] v, input string name);
        bus.Addr = 2'd2;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (bus.DOut == v) break;
        end
        check(name, bus.DOut, v);
    endtask

    task automatic reset_mid(input string name);
        bus.Addr = 2'd2;
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check({name, "_irq"}, {31'd0, bus.IRQ}, 32'd0);
        check({name, "_count"}, bus.DOut, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int a = 0; a < 4; a++) rd_expect(2'(a), 32'd0, {name, "_regs"});
    endtask

    initial begin
        bus.Addr = 2'd0;
        bus.We   = 1'b0;
        bus.DIn  = 32'd0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        for (int a = 0; a < 4; a++) rd_expect(2'(a), 32'd0, "reset_read");
        check("reset_irq", {31'd0, bus.IRQ}, 32'd0);

        // One-shot: PRESET=5 -> IRQ after E7, held; Enable self-clears.
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        e0 = edge_cnt;
        wait_irq(e0, 7, "oneshot_irq_edge");
        repeat (4) @(posedge clk);
        #1 check("oneshot_irq_held", {31'd0, bus.IRQ}, 32'd1);
        rd_expect(2'd0, 32'h8, "oneshot_ctrl");
        wr(2'd0, 32'h8);
        check("oneshot_irq_clear", {31'd0, bus.IRQ}, 32'd0);

        // Async reset while IRQ is high, then while counting at 7.
        wr(2'd0, 32'h9);
        e0 = edge_cnt;
        wait_irq(e0, 7, "oneshot_again");
        reset_mid("reset_irq_high");
        wr(2'd1, 32'd9);
        wr(2'd0, 32'h9);
        poll_count(32'd7, "reach_count7");
        reset_mid("reset_count7");

        // Auto-reload: PRESET=3 -> pulse after E5, then every 5 edges.
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        e0 = edge_cnt;
        bus.Addr = 2'd2;
        wait_irq(e0, 5, "reload_first");
        e1 = edge_cnt;
        @(posedge clk);
        #1 check("reload_pulse_width", {31'd0, bus.IRQ}, 32'd0);
        wait_irq(e1, 5, "reload_period1");
        e1 = edge_cnt;
        @(posedge clk);
        #1 wait_irq(e1, 5, "reload_period2");
        wr(2'd0, 32'h0);

        // Masked interrupt.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        repeat (8) @(posedge clk);
        #1 check("mask_irq", {31'd0, bus.IRQ}, 32'd0);
        rd_expect(2'd0, 32'h0, "mask_ctrl");
        rd_expect(2'd2, 32'h0, "mask_count");

        // Disable mid-count: Enable clear lands as COUNT becomes 4, which then holds.
        wr(2'd1, 32'd8);
        wr(2'd0, 32'h1);
        poll_count(32'd5, "reach_count5");
        wr_now(2'd0, 32'h0);
        repeat (4) @(posedge clk);
        #1 rd_expect(2'd2, 32'd4, "disable_hold");
        check("disable_irq", {31'd0, bus.IRQ}, 32'd0);
        wr(2'd2, 32'h77);
        rd_expect(2'd2, 32'd4, "count_readonly");

        // PRESET 0 and 1 both expire after E3.
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        e0 = edge_cnt;
        wait_irq(e0, 3, "preset0_irq");
        wr(2'd0, 32'h0);
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        e0 = edge_cnt;
        wait_irq(e0, 3, "preset1_irq");
        wr(2'd0, 32'h0);

        // PRESET rewritten mid-count does not stretch the current period.
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        e0 = edge_cnt;
        repeat (4) @(posedge clk);
        wr(2'd1, 32'd100);
        wait_irq(e0, 12, "preset_midcount");
        wr(2'd0, 32'h0);

        // CTRL write on the same edge as the one-shot Enable clear.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        e0 = edge_cnt;
        wait_irq(e0, 4, "collide_irq");
        wr_now(2'd0, 32'hD);
        rd_expect(2'd0, 32'hD, "collide_ctrl");
        check("collide_flag_clr", {31'd0, bus.IRQ}, 32'd0);
        wr(2'd0, 32'h0);

`ifdef TIMER_PRESCALE_EN
        wr(2'd3, 32'h1FF);
        rd_expect(2'd3, 32'hFF, "prescale_width");
        wr(2'd3, 32'd2);
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        e0 = edge_cnt;
        wait_irq(e0, 11, "prescale_irq");
        wr(2'd0, 32'h0);
        wr(2'd3, 32'd0);
`else
        wr(2'd3, 32'hFF);
        rd_expect(2'd3, 32'h0, "addr3_zero");
`endif
        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
